// File: rtl/ats21_pkg.sv
// ats21_pkg: shared opcode, client and command types for the ATS21 command receiver
package ats21_pkg;
    typedef enum logic [2:0] {
        NOP       = 3'b000,
        SET_CLK   = 3'b001,
        TOG_BC    = 3'b010,
        SET_MODE  = 3'b011,
        ILLEGAL   = 3'b100,
        SET_ALARM = 3'b101,
        SET_CNTDN = 3'b110,
        TOG_AT    = 3'b111
    } opcode_e;
    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } client_e;
    typedef struct packed {
        client_e     client;
        opcode_e     opcode;
        logic [31:0] word;
    } cmd_t;
    function automatic logic is_legal(opcode_e op);
        return op != NOP && op != ILLEGAL;
    endfunction
endpackage

// File: rtl/ats21_cmd_fifo.sv
// ats21_cmd_fifo: show-ahead command FIFO with two ordered write ports and one read port
module ats21_cmd_fifo
    import ats21_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr0_en,
    input  cmd_t                       wr0_data,
    input  logic                       wr1_en,
    input  cmd_t                       wr1_data,
    input  logic                       rd_en,
    output cmd_t                       rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    cmd_t             mem_q [DEPTH];
    cmd_t             mem_d [DEPTH];
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d, wp1;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;
    always_comb begin
        mem_d   = mem_q;
        pop     = rd_en && count_q != '0;
        wp1     = wp_q + AW'(wr0_en);
        if (wr0_en) mem_d[wp_q] = wr0_data;
        if (wr1_en) mem_d[wp1] = wr1_data;
        wp_d    = wp1 + AW'(wr1_en);
        rp_d    = rp_q + AW'(pop);
        count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end
    assign rd_data = mem_q[rp_q];
    assign count   = count_q;
endmodule

// File: rtl/ats21_instr_rx.sv
// ats21_instr_rx: two-word instruction capture for clients A/B, opcode screening and command queueing
module ats21_instr_rx
    import ats21_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [15:0]      ctrlA,
    input  logic [15:0]      ctrlB,
    output logic             ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_client,
    output logic [2:0]       cmd_opcode,
    output logic [31:0]      cmd_word,
    output logic [CNT_W-1:0] fifo_count,
    output logic             illegal_op,
    output logic             proto_err,
    output logic             overflow
);
    typedef enum logic {IDLE, LOWER} state_e;
    state_e      state_q, state_d;
    logic [15:0] hia_q, hia_d, hib_q, hib_d;
    logic        ill_q, ill_d, proto_q, proto_d, ovf_q, ovf_d;
    logic        la, lb, fit, done;
    cmd_t        cmd_a, cmd_b, head;
    assign la    = is_legal(opcode_e'(hia_q[15:13]));
    assign lb    = is_legal(opcode_e'(hib_q[15:13]));
    assign fit   = CNT_W'(DEPTH) - fifo_count >= CNT_W'(la) + CNT_W'(lb);
    assign done  = state_q == LOWER && !req;
    assign cmd_a = '{client: CLIENT_A, opcode: opcode_e'(hia_q[15:13]), word: {hia_q, ctrlA}};
    assign cmd_b = '{client: CLIENT_B, opcode: opcode_e'(hib_q[15:13]), word: {hib_q, ctrlB}};
    assign ready = reset && state_q == IDLE && CNT_W'(DEPTH) - fifo_count >= CNT_W'(2);
    always_comb begin
        state_d = state_q;
        hia_d   = hia_q;
        hib_d   = hib_q;
        ill_d   = 1'b0;
        proto_d = 1'b0;
        ovf_d   = 1'b0;
        if (state_q == IDLE) begin
            if (req && ready) begin
                hia_d   = ctrlA;
                hib_d   = ctrlB;
                state_d = LOWER;
            end else if (req) begin
                ovf_d = 1'b1;
            end
        end else if (req) begin
            proto_d = 1'b1;
            hia_d   = ctrlA;
            hib_d   = ctrlB;
        end else begin
            state_d = IDLE;
            ill_d   = hia_q[15:13] == 3'(ILLEGAL) || hib_q[15:13] == 3'(ILLEGAL);
            ovf_d   = !fit;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hia_q   <= '0;
            hib_q   <= '0;
            ill_q   <= 1'b0;
            proto_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hia_q   <= hia_d;
            hib_q   <= hib_d;
            ill_q   <= ill_d;
            proto_q <= proto_d;
            ovf_q   <= ovf_d;
        end
    end
    ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr0_en   (done && fit && (la || lb)),
        .wr0_data (la ? cmd_a : cmd_b),
        .wr1_en   (done && fit && la && lb),
        .wr1_data (cmd_b),
        .rd_en    (cmd_ready),
        .rd_data  (head),
        .count    (fifo_count)
    );
    assign cmd_valid  = fifo_count != '0;
    assign cmd_client = head.client;
    assign cmd_opcode = head.opcode;
    assign cmd_word   = head.word;
    assign illegal_op = ill_q;
    assign proto_err  = proto_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ats21_instr_rx.sv
// tb_ats21_instr_rx: directed scenario bench for the ATS21 command receiver
module tb_ats21_instr_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [15:0] ctrlA = '0, ctrlB = '0;
    logic        ready, cmd_valid, cmd_client, illegal_op, proto_err, overflow;
    logic        cmd_ready = 1'b0;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_word;
    logic [2:0]  fifo_count;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    ats21_instr_rx #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
        .ready(ready), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_client(cmd_client), .cmd_opcode(cmd_opcode), .cmd_word(cmd_word),
        .fifo_count(fifo_count), .illegal_op(illegal_op), .proto_err(proto_err),
        .overflow(overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] ah, bh, al, bl);
        req = 1'b1; ctrlA = ah; ctrlB = bh;
        step();
        req = 1'b0; ctrlA = al; ctrlB = bl;
        step();
        ctrlA = '0; ctrlB = '0;
    endtask

    task automatic pop();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++; if ({ready, cmd_valid, illegal_op, proto_err, overflow} !== 5'b0) begin failures++; $display("FAIL reset_outs got=%b exp=00000", {ready, cmd_valid, illegal_op, proto_err, overflow}); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        step();
    endtask

    task automatic test_set_clk();
        send(16'h2000, 16'h2240, 16'h0000, 16'h0000);
        checks++; if (cmd_valid !== 1'b1) begin failures++; $display("FAIL setclk_valid got=%b exp=1", cmd_valid); end
        checks++; if (cmd_client !== 1'b0) begin failures++; $display("FAIL setclk_client0 got=%b exp=0", cmd_client); end
        checks++; if (cmd_word !== 32'h20000000) begin failures++; $display("FAIL setclk_word0 got=%h exp=20000000", cmd_word); end
        checks++; if (cmd_opcode !== 3'b001) begin failures++; $display("FAIL setclk_op0 got=%b exp=001", cmd_opcode); end
        checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL setclk_count got=%0d exp=2", fifo_count); end
        pop();
        checks++; if (cmd_client !== 1'b1) begin failures++; $display("FAIL setclk_client1 got=%b exp=1", cmd_client); end
        checks++; if (cmd_word !== 32'h22400000) begin failures++; $display("FAIL setclk_word1 got=%h exp=22400000", cmd_word); end
        pop();
        checks++; if (fifo_count !== 3'd0 || cmd_valid !== 1'b0) begin failures++; $display("FAIL setclk_drain got=%0d/%b exp=0/0", fifo_count, cmd_valid); end
    endtask

    task automatic test_a_only();
        send(16'hA080, 16'h0000, 16'h0100, 16'h0000);
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL aonly_count got=%0d exp=1", fifo_count); end
        checks++; if ({cmd_client, cmd_opcode} !== 4'b0101) begin failures++; $display("FAIL aonly_cl_op got=%b exp=0101", {cmd_client, cmd_opcode}); end
        checks++; if (cmd_word !== 32'hA0800100) begin failures++; $display("FAIL aonly_word got=%h exp=a0800100", cmd_word); end
        pop();
    endtask

    task automatic test_illegal();
        send(16'h8000, 16'hC100, 16'h1234, 16'h0010);
        checks++; if (illegal_op !== 1'b1) begin failures++; $display("FAIL illegal_pulse got=%b exp=1", illegal_op); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL illegal_count got=%0d exp=1", fifo_count); end
        checks++; if ({cmd_client, cmd_opcode} !== 4'b1110) begin failures++; $display("FAIL illegal_cl_op got=%b exp=1110", {cmd_client, cmd_opcode}); end
        checks++; if (cmd_word !== 32'hC1000010) begin failures++; $display("FAIL illegal_word got=%h exp=c1000010", cmd_word); end
        step();
        checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL illegal_once got=%b exp=0", illegal_op); end
        pop();
    endtask

    task automatic test_proto();
        req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h0000;
        step();
        ctrlA = 16'h4080;
        step();
        req = 1'b0; ctrlA = 16'h0000;
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_pulse got=%b exp=1", proto_err); end
        step();
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL proto_once got=%b exp=0", proto_err); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL proto_count got=%0d exp=1", fifo_count); end
        checks++; if (cmd_word !== 32'h40800000) begin failures++; $display("FAIL proto_word got=%h exp=40800000", cmd_word); end
        pop();
    endtask

    task automatic test_overflow();
        send(16'h2000, 16'h2240, 16'h0001, 16'h0002);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_half got=%b exp=1", ready); end
        send(16'h6000, 16'hE000, 16'h0003, 16'h0004);
        checks++; if (fifo_count !== 3'd4 || ready !== 1'b0) begin failures++; $display("FAIL ovf_full got=%0d/%b exp=4/0", fifo_count, ready); end
        req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h2000;
        step();
        req = 1'b0; ctrlA = 16'h0000; ctrlB = 16'h0000;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        step();
        checks++; if (overflow !== 1'b0 || fifo_count !== 3'd4) begin failures++; $display("FAIL ovf_after got=%b/%0d exp=0/4", overflow, fifo_count); end
        pop(); pop();
        checks++; if (ready !== 1'b1 || fifo_count !== 3'd2) begin failures++; $display("FAIL ovf_recover got=%b/%0d exp=1/2", ready, fifo_count); end
        checks++; if (cmd_word !== 32'h60000003 || cmd_client !== 1'b0) begin failures++; $display("FAIL ovf_head got=%h/%b exp=60000003/0", cmd_word, cmd_client); end
        pop();
        checks++; if (cmd_word !== 32'hE0000004 || cmd_opcode !== 3'b111) begin failures++; $display("FAIL ovf_wrap got=%h/%b exp=e0000004/111", cmd_word, cmd_opcode); end
        pop();
    endtask

    task automatic test_reset_mid();
        req = 1'b1; ctrlA = 16'h2000; ctrlB = 16'h3000;
        step();
        req = 1'b0; ctrlA = 16'h0001; ctrlB = 16'h0002; reset = 1'b0;
        #1;
        checks++; if ({ready, cmd_valid, illegal_op, proto_err, overflow, fifo_count} !== 8'b0) begin failures++; $display("FAIL rstmid_outs got=%b exp=00000000", {ready, cmd_valid, illegal_op, proto_err, overflow, fifo_count}); end
        step();
        reset = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        step();
        checks++; if ({cmd_valid, illegal_op, proto_err, overflow, fifo_count} !== 7'b0) begin failures++; $display("FAIL rstmid_quiet got=%b exp=0000000", {cmd_valid, illegal_op, proto_err, overflow, fifo_count}); end
        send(16'h6000, 16'h0000, 16'h0005, 16'h0000);
        checks++; if (fifo_count !== 3'd1 || cmd_word !== 32'h60000005 || cmd_opcode !== 3'b011) begin failures++; $display("FAIL rstmid_next got=%0d/%h/%b exp=1/60000005/011", fifo_count, cmd_word, cmd_opcode); end
        pop();
    endtask

    task automatic test_back_to_back();
        send(16'h2000, 16'h0000, 16'h0000, 16'h0000);
        send(16'h0000, 16'hE000, 16'h0000, 16'h0001);
        checks++; if (fifo_count !== 3'd2 || cmd_word !== 32'h20000000) begin failures++; $display("FAIL b2b_head got=%0d/%h exp=2/20000000", fifo_count, cmd_word); end
        pop();
        checks++; if ({cmd_client, cmd_opcode} !== 4'b1111 || cmd_word !== 32'hE0000001) begin failures++; $display("FAIL b2b_second got=%b/%h exp=1111/e0000001", {cmd_client, cmd_opcode}, cmd_word); end
        pop();
        checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", cmd_valid); end
    endtask

    initial begin
        test_reset();
        test_set_clk();
        test_a_only();
        test_illegal();
        test_proto();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ats21_instr_rx.md
Name: ats21_instr_rx

Overview:
- Receive end of the ATS21 client command interface: one `req`, two 16-bit control buses (`ctrlA`, `ctrlB`), each instruction sent as two words on consecutive cycles.
- Captures both clients' words, classifies opcodes and drops Nops. Illegal opcodes and protocol violations are flagged.
- Queues decoded commands in a small FIFO, served to the ATS21 core through a valid/ready handshake.
- Drives the DUT-level `ready` output.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of `fifo_count`.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  high for one cycle: first (upper) words are present on ctrlA/ctrlB this cycle.
- ctrlA  in  16  client A word: upper word in the req cycle, lower word the next cycle.
- ctrlB  in  16  client B word, same timing as ctrlA.
- ready  out  1  block can accept a new transaction.
- cmd_valid  out  1  FIFO head holds a command.
- cmd_ready  in  1  core accepts the head command.
- cmd_client  out  1  0 = A, 1 = B.
- cmd_opcode  out  3  opcode, bits [31:29] of the instruction.
- cmd_word  out  32  full instruction {upper, lower}.
- fifo_count  out  CNT_W  current FIFO occupancy.
- illegal_op  out  1  one-cycle pulse: opcode 100 received.
- proto_err  out  1  one-cycle pulse: req seen in a lower-word cycle.
- overflow  out  1  one-cycle pulse: transaction dropped because the FIFO lacked room.

Behaviour:
- Reset, async on reset low:
  - FSM goes to IDLE; FIFO is emptied.
  - All outputs are 0, except `ready`, which is 1 as soon as reset is released.
- Opcodes:
  - 000 = Nop: not queued.
  - 001, 010, 011, 101, 110, 111: legal, queued.
  - 100: illegal; not queued; `illegal_op` pulses.
- FSM has two states, IDLE and LOWER.
- IDLE:
  - On `req`=1, register `ctrlA` and `ctrlB` as upper words (hiA, hiB) and go to LOWER.
  - `req` is honoured only when `ready`=1.
  - `req` with `ready`=0 is ignored and pulses `overflow` the next cycle.
- LOWER, cycle T+1 when `req` rose at T:
  - Register loA and loB.
  - Form instA = {hiA, loA} and instB = {hiB, loB}.
  - Return to IDLE.
- LOWER with `req`=1 (protocol violation):
  - Discard the pending hi words.
  - Pulse `proto_err` at T+2.
  - Treat the current `ctrlA`/`ctrlB` as new upper words and stay in LOWER (restart).
- Enqueue, on the T+1 edge:
  - Write legal instA, then legal instB; A always precedes B.
  - 0, 1 or 2 writes in one cycle.
  - Commands are visible on `cmd_*` at T+2 at the earliest.
  - `illegal_op` pulses at T+2 if either client sent 100. A and B in the same cycle give one pulse.
- Room check:
  - Use occupancy at T+1, ignoring any same-cycle pop.
  - If free slots < number of legal instructions, drop the whole transaction (neither entry written) and pulse `overflow` at T+2.
- ready = (state==IDLE) && (DEPTH − fifo_count ≥ 2).
- FIFO output:
  - Show-ahead: `cmd_*` reflect the head whenever `cmd_valid`=1.
  - Pop when `cmd_valid` && `cmd_ready`.
  - `cmd_*` values are don't-care when `cmd_valid`=0.
  - Push and pop in the same cycle are allowed: count changes by pushes − pops.
  - Pointers wrap modulo DEPTH.
- `fifo_count` is registered and never exceeds DEPTH.
- Reset mid-transaction discards captured words; no pulses are generated.

Decomposition:
- ats21_pkg holds:
  - `opcode_e`: NOP=000, SET_CLK=001, TOG_BC=010, SET_MODE=011, ILLEGAL=100, SET_ALARM=101, SET_CNTDN=110, TOG_AT=111.
  - `client_e` (A=0, B=1).
  - `cmd_t` struct {client, opcode, word[31:0]}.
  - A function `is_legal(opcode)`.
- Sub-module ats21_cmd_fifo:
  - Parameterised on DEPTH; stores `cmd_t`.
  - Two ordered write ports (wr0 before wr1), one read port.
  - Provides a count output.

Test Plan:
1. Set clocks on both clients: reset; req with A=0x2000/0x0000 and B=0x2240/0x0000.
   - → At T+2: cmd_valid=1, head client=A, word=0x20000000, opcode=001, fifo_count=2.
   - → After one pop: client=B, word=0x22400000.
2. A only, B Nop: A=0xA080/0x0100, B=0x0000/0x0000.
   - → Single entry: client=A, opcode=101, word=0xA0800100; fifo_count=1.
3. Illegal opcode: A=0x8000/0x1234, B=0xC100/0x0010.
   - → illegal_op pulses at T+2.
   - → Only B queued: word=0xC1000010, opcode=110.
4. Protocol violation: req high for 2 consecutive cycles with A=0x2000 then A=0x4080, followed by A=0x0000.
   - → proto_err pulses once.
   - → One entry queued: word=0x40800000.
5. Overflow, DEPTH=4, cmd_ready=0:
   - → Two dual-legal transactions fill the FIFO; ready=0.
   - → A third req is ignored, overflow pulses, fifo_count stays 4.
   - → Popping 2 entries restores ready=1.
6. Reset mid-transaction: assert reset low the cycle after req.
   - → All outputs 0, fifo_count=0, no pulses.
   - → ready=1 after release; the next transaction queues normally.
